// File: rtl/bu_rs.sv
// Branch unit with an age-ordered reservation buffer, CDB wakeup and a registered result stage.
// Define BU_SYS_STACK_EN to turn the ECALL return store into a SYS_STACK_DEPTH-entry LIFO.
package bu_rs_pkg;
  typedef enum logic [2:0] {BRANCH, JAL, JALR, AUIPC, ECALL, ERET} insn_t;
  typedef enum logic [2:0] {BEQ, BNE, BLT, BGE, BLTU, BGEU} cond_t;
  typedef enum logic {USER, SUPERVISOR} cpl_t;
  localparam int unsigned IMM_WIDTH = 32;
  typedef struct packed {
    insn_t                insn;
    cond_t                cond;
    logic [IMM_WIDTH-1:0] imm;
  } op_t;
endpackage

module bu_rs
  import bu_rs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned SYS_STACK_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] PRIV_ROUTINE_START = DATA_WIDTH'(32'h0001_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [TAG_WIDTH-1:0]  alloc_tag_i,
  input  op_t                   alloc_op_i,
  input  logic [DATA_WIDTH-1:0] alloc_pc_i,
  input  logic [DATA_WIDTH-1:0] alloc_lhs_i,
  input  logic [DATA_WIDTH-1:0] alloc_rhs_i,
  input  logic                  alloc_lhs_valid_i,
  input  logic                  alloc_rhs_valid_i,
  input  logic [TAG_WIDTH-1:0]  alloc_lhs_tag_i,
  input  logic [TAG_WIDTH-1:0]  alloc_rhs_tag_i,
  input  logic                  cdb_valid_i,
  input  logic [TAG_WIDTH-1:0]  cdb_tag_i,
  input  logic [DATA_WIDTH-1:0] cdb_data_i,
  input  cpl_t                  cpl_i,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [TAG_WIDTH-1:0]  res_tag_o,
  output logic [DATA_WIDTH-1:0] res_pc_o,
  output logic [DATA_WIDTH-1:0] res_rd_o,
  output logic                  res_pc_valid_o,
  output logic                  res_rd_valid_o,
  output logic                  res_fault_o,
  input  logic                  retire_i,
  input  op_t                   retire_op_i,
  input  logic [DATA_WIDTH-1:0] retire_pc_i,
  output logic                  stack_fault_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef struct packed {
    logic [TAG_WIDTH-1:0]  tag;
    op_t                   op;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic                  lhs_v;
    logic                  rhs_v;
    logic [TAG_WIDTH-1:0]  lhs_tag;
    logic [TAG_WIDTH-1:0]  rhs_tag;
  } ent_t;

  function automatic ent_t wake(input ent_t e, input logic v, input logic [TAG_WIDTH-1:0] t,
                                input logic [DATA_WIDTH-1:0] d);
    ent_t r;
    r = e;
    if (v && !e.lhs_v && e.lhs_tag == t) begin r.lhs = d; r.lhs_v = 1'b1; end
    if (v && !e.rhs_v && e.rhs_tag == t) begin r.rhs = d; r.rhs_v = 1'b1; end
    return r;
  endfunction

  function automatic logic op_ready(input ent_t e);
    logic need_l, need_r;
    need_l = (e.op.insn == BRANCH) || (e.op.insn == JALR);
    need_r = (e.op.insn == BRANCH);
    return (!need_l || e.lhs_v) && (!need_r || e.rhs_v);
  endfunction

  ent_t                  ent_q [DEPTH];
  ent_t                  ent_w [DEPTH];
  ent_t                  ent_d [DEPTH];
  ent_t                  ent_raw, ent_new, iss;
  logic [CW-1:0]         count_q, count_d, count_after;
  logic [DEPTH-1:0]      rdy;
  logic [IW-1:0]         sel;
  logic                  any_rdy, can_issue, issue_buf, byp, do_issue, alloc_fire, alloc_rdy;
  logic [DATA_WIDTH-1:0] ret_top, tgt, rd, pc4, imm_s, br_s;
  logic                  pc_v, rd_v, taken, fault;

  assign alloc_fire = alloc_valid_i && alloc_ready_o && !flush_i;
  assign can_issue  = !res_valid_o || res_ready_i;

  // Wakeup of stored entries; readiness uses pre-wakeup state so CDB hits issue a cycle later.
  always_comb begin
    ent_raw.tag     = alloc_tag_i;
    ent_raw.op      = alloc_op_i;
    ent_raw.pc      = alloc_pc_i;
    ent_raw.lhs     = alloc_lhs_i;
    ent_raw.rhs     = alloc_rhs_i;
    ent_raw.lhs_v   = alloc_lhs_valid_i;
    ent_raw.rhs_v   = alloc_rhs_valid_i;
    ent_raw.lhs_tag = alloc_lhs_tag_i;
    ent_raw.rhs_tag = alloc_rhs_tag_i;
    ent_new         = wake(ent_raw, cdb_valid_i, cdb_tag_i, cdb_data_i);
    alloc_rdy       = op_ready(ent_raw);
    any_rdy         = 1'b0;
    sel             = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = wake(ent_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
      rdy[i]   = (CW'(i) < count_q) && op_ready(ent_q[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        any_rdy = 1'b1;
        sel     = IW'(i);
      end
    end
  end

  // A ready op arriving when nothing older is ready skips the buffer entirely.
  assign issue_buf = any_rdy && can_issue && !flush_i;
  assign byp       = alloc_fire && alloc_rdy && !any_rdy && can_issue;
  assign do_issue  = issue_buf || byp;

  // Compaction behind the issued slot, then append the allocating op at the tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_w[i];
    if (issue_buf) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IW'(i) >= sel) ent_d[i] = ent_w[i+1];
      end
    end
    count_after = count_q - CW'(issue_buf);
    if (alloc_fire && !byp) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_after) ent_d[i] = ent_new;
      end
    end
    count_d = count_after + CW'(alloc_fire && !byp);
    if (flush_i) count_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      alloc_ready_o <= 1'b1;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q       <= count_d;
      alloc_ready_o <= count_d < CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  // Target, link value and privilege check for the issuing op.
  always_comb begin
    iss   = any_rdy ? ent_q[sel] : ent_raw;
    pc4   = iss.pc + DATA_WIDTH'(4);
    imm_s = DATA_WIDTH'($signed(iss.op.imm));
    br_s  = DATA_WIDTH'($signed(iss.op.imm[12:0]));
    tgt   = '0;
    rd    = '0;
    pc_v  = 1'b0;
    rd_v  = 1'b0;
    case (iss.op.cond)
      BEQ:     taken = iss.lhs == iss.rhs;
      BNE:     taken = iss.lhs != iss.rhs;
      BLT:     taken = $signed(iss.lhs) < $signed(iss.rhs);
      BGE:     taken = $signed(iss.lhs) >= $signed(iss.rhs);
      BLTU:    taken = iss.lhs < iss.rhs;
      BGEU:    taken = iss.lhs >= iss.rhs;
      default: taken = 1'b0;
    endcase
    case (iss.op.insn)
      BRANCH:  begin tgt = taken ? iss.pc + br_s : pc4; pc_v = 1'b1; end
      JAL:     begin tgt = iss.pc + imm_s; rd = pc4; pc_v = 1'b1; rd_v = 1'b1; end
      JALR:    begin tgt = iss.lhs + imm_s; rd = pc4; pc_v = 1'b1; rd_v = 1'b1; end
      AUIPC:   begin rd = iss.pc + imm_s; rd_v = 1'b1; end
      ECALL:   begin tgt = PRIV_ROUTINE_START; pc_v = 1'b1; end
      ERET:    begin tgt = ret_top; pc_v = 1'b1; end
      default: ;
    endcase
    fault = pc_v && (tgt >= PRIV_ROUTINE_START) && (iss.op.insn != ECALL) && (cpl_i == USER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_o    <= 1'b0;
      res_tag_o      <= '0;
      res_pc_o       <= '0;
      res_rd_o       <= '0;
      res_pc_valid_o <= 1'b0;
      res_rd_valid_o <= 1'b0;
      res_fault_o    <= 1'b0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
    end else if (do_issue) begin
      res_valid_o    <= 1'b1;
      res_tag_o      <= iss.tag;
      res_pc_o       <= tgt;
      res_rd_o       <= rd;
      res_pc_valid_o <= pc_v && !fault;
      res_rd_valid_o <= rd_v;
      res_fault_o    <= fault;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  logic unused_retire;
  assign unused_retire = ^{retire_op_i.cond, retire_op_i.imm};

`ifdef BU_SYS_STACK_EN
  localparam int unsigned SCW = $clog2(SYS_STACK_DEPTH + 1);
  logic [DATA_WIDTH-1:0] stk_q [SYS_STACK_DEPTH];
  logic [SCW-1:0]        sp_q;
  logic                  push, pop, push_f, pop_f, read_f;

  assign push    = retire_i && (retire_op_i.insn == ECALL);
  assign pop     = retire_i && (retire_op_i.insn == ERET);
  assign push_f  = push && (sp_q == SCW'(SYS_STACK_DEPTH));
  assign pop_f   = pop && (sp_q == '0);
  assign read_f  = do_issue && (iss.op.insn == ERET) && (sp_q == '0);
  assign ret_top = stk_q[0];

  // Top lives in slot 0; vacated slots fill with 0 so an empty stack reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q          <= '0;
      stack_fault_o <= 1'b0;
      for (int i = 0; i < SYS_STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      stack_fault_o <= push_f || pop_f || read_f;
      if (push) begin
        for (int i = 1; i < SYS_STACK_DEPTH; i++) stk_q[i] <= stk_q[i-1];
        stk_q[0] <= retire_pc_i + DATA_WIDTH'(4);
        if (!push_f) sp_q <= sp_q + SCW'(1);
      end else if (pop) begin
        for (int i = 0; i < SYS_STACK_DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
        stk_q[SYS_STACK_DEPTH-1] <= '0;
        if (!pop_f) sp_q <= sp_q - SCW'(1);
      end
    end
  end
`else
  logic [DATA_WIDTH-1:0] ret_q;
  assign ret_top       = ret_q;
  assign stack_fault_o = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_q <= '0;
    end else if (retire_i) begin
      if (retire_op_i.insn == ECALL)     ret_q <= retire_pc_i + DATA_WIDTH'(4);
      else if (retire_op_i.insn == ERET) ret_q <= '0;
    end
  end
`endif
endmodule

// File: doc/bu_rs.md
# bu_rs

Parametrised branch unit with a built-in reservation buffer. It accepts up to DEPTH branch-class ops (BRANCH, JAL, JALR, AUIPC, ECALL, ERET) from dispatch and captures missing operands from the common data bus. It issues the oldest ready op each cycle and returns a registered, tagged result to the reorder logic. Illegal privileged jumps are reported as a fault instead of halting simulation, and ECALL return addresses are tracked for ERET.

## Interface
- DATA_WIDTH, 64, operand/PC width
- DEPTH, 4, reservation entries (2..16)
- TAG_WIDTH, 4, ROB/CDB tag width
- SYS_STACK_DEPTH, 4, return-address stack entries (only with BU_SYS_STACK_EN)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  discard all entries and the pending result
- alloc_valid_i / alloc_ready_o  in/out  1  dispatch handshake
- alloc_tag_i  in  TAG_WIDTH  ROB tag of op
- alloc_op_i  in  op_t  decoded op (insn, imm)
- alloc_pc_i  in  DATA_WIDTH  op PC
- alloc_lhs_i, alloc_rhs_i  in  DATA_WIDTH  operand values
- alloc_lhs_valid_i, alloc_rhs_valid_i  in  1  operand present
- alloc_lhs_tag_i, alloc_rhs_tag_i  in  TAG_WIDTH  producer tag when not present
- cdb_valid_i, cdb_tag_i, cdb_data_i  in  1/TAG_WIDTH/DATA_WIDTH  wakeup broadcast
- cpl_i  in  enum {USER, SUPERVISOR}  current privilege level
- res_valid_o / res_ready_i  out/in  1  result handshake
- res_tag_o  out  TAG_WIDTH
- res_pc_o, res_rd_o  out  DATA_WIDTH  redirect target, link/AUIPC value
- res_pc_valid_o, res_rd_valid_o  out  1
- res_fault_o  out  1  illegal jump; res_pc_valid_o forced 0
- retire_i  in  1  ECALL/ERET of res tag committed
- retire_op_i, retire_pc_i  in  op_t/DATA_WIDTH  committed op and its PC
- stack_fault_o  out  1  one-cycle pulse on stack overflow/underflow

## Operation
- Entries are age-ordered; alloc writes the youngest slot when alloc_valid_i && alloc_ready_o; alloc_ready_o = (count < DEPTH), registered (no same-cycle free-and-fill).
- Operands needed: BRANCH lhs+rhs; JALR lhs; others none.
- CDB match (cdb_valid_i, tag equal, operand not valid) sets value/valid; same-cycle CDB match on an allocating op is captured.
- Select: oldest entry with needed operands valid, when the output register is empty or being drained (res_ready_i). Selected entry leaves; younger entries compact.
- Targets: BRANCH taken pc+sext13(imm), else pc+4; JAL pc+imm, rd pc+4; JALR lhs+imm (bit 0 kept as is), rd pc+4; AUIPC rd pc+imm; ECALL PRIV_ROUTINE_START; ERET top of return store. All arithmetic is mod 2^DATA_WIDTH.
- Fault: res_pc_valid would be 1, target >= PRIV_ROUTINE_START, op != ECALL, cpl_i == USER -> res_fault_o=1, res_pc_valid_o=0, rd fields unchanged.
- Dispatch serialises ECALL/ERET (issued only when the ROB is empty), so ERET reads a committed top.
- Retire ECALL: push retire_pc_i+4. Retire ERET: pop.
- flush_i: count=0, res_valid_o=0; return store unchanged.

## Timing
- Reset: count=0, alloc_ready_o=1, res_valid_o=0, all res_* flags 0, data outputs 0, stack empty, stack_fault_o=0.
- Latency: ready-at-alloc op -> res_valid_o next cycle. CDB wakeup in cycle N -> issue eligible in cycle N+1, result in N+2.
- res_* held stable while res_valid_o && !res_ready_i; one result per cycle sustained.
- flush_i wins over alloc and issue in the same cycle.
- Reset asserted mid-operation clears state immediately; outputs return to reset values asynchronously.

## Configuration
- BU_SYS_STACK_EN defined: SYS_STACK_DEPTH-entry LIFO. Push when full drops the oldest entry and pulses stack_fault_o. Pop or ERET-read when empty yields 0 and pulses stack_fault_o.
- Undefined: a single register; ECALL overwrites it, ERET retire clears it to 0. stack_fault_o is tied to 0.

## Test plan
- JAL pc=0x1000, imm=0x20, alloc cycle 0 -> cycle 1: res_pc=0x1020, res_rd=0x1004, both valid, tag echoed.
- BEQ lhs waiting on tag 3, rhs=5; cycle 2 CDB tag 3 data 5 -> cycle 4 res_pc=pc+imm; data 6 -> res_pc=pc+4.
- Fill 4 entries with stalled JALRs -> alloc_ready_o=0; wake entry 2 first -> it issues first; then wake all -> remaining results in age order.
- USER JAL targeting PRIV_ROUTINE_START -> res_fault_o=1, res_pc_valid_o=0; same op in SUPERVISOR -> normal redirect.
- Retire ECALLs at pc 0x100 and 0x200, then two ERETs -> targets 0x204, 0x104; a third ERET -> target 0, stack_fault_o pulse (with BU_SYS_STACK_EN).
- res_ready_i=0 for 3 cycles with a ready entry behind -> outputs stable; flush_i then rst mid-stream -> count 0, res_valid_o 0 next edge/immediately.
